fetch_branch_resolve: RTL and testbench

// - Update-side partner of the fetch branch cache: tracks every predicted branch from decode until execute resolves it.
// - On resolve, drives the cache update port (JUMP_*) one cycle later, detects mispredictions and raises redirect + PC.
// - Sits between decode (push) and execute (resolve); in-order, one resolve per pushed branch.

---
 rtl/fetch_branch_pkg.sv | 34 +++
 rtl/fetch_branch_resolve_fifo.sv | 58 +++++
 rtl/fetch_branch_resolve.sv | 119 +++++++++++
 tb/tb_fetch_branch_resolve.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_branch_pkg.sv
// Shared types for the fetch branch cache update path.
// Branch entry layout, resolve FSM states and predictor encodings.
package fetch_branch_pkg;

   localparam logic [1:0] PRED_STRONG_TAKEN = 2'h3;
   localparam logic [1:0] PRED_STRONG_NOT   = 2'h0;
   localparam logic [1:0] PRED_WEAK_NOT     = 2'h1;
   localparam logic [1:0] PRED_WEAK_TAKEN   = 2'h2;

   typedef struct packed {
      logic [31:0] inst_addr;
      logic        hit;
      logic        predict;
      logic [31:0] target;
   } branch_entry_t;

   typedef enum logic {
      RUN       = 1'b0,
      MISS_WAIT = 1'b1
   } state_t;

   // Taken prediction needs a cache hit; a taken-taken pair also needs matching targets.
   function automatic logic is_mispredict(
      input branch_entry_t e,
      input logic          jump,
      input logic [31:0]   addr
   );
      logic taken_pred;
      taken_pred = e.hit & e.predict;
      return (taken_pred != jump) ||
             (taken_pred && jump && (e.target != addr));
   endfunction

endpackage

// File: rtl/fetch_branch_resolve_fifo.sv
// In-order queue of predicted branches awaiting resolution.
// Clear wins over push/pop; push while full is legal only with a pop.
module fetch_branch_resolve_fifo
   import fetch_branch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          iCLOCK,
   input  logic          iRESET_SYNC,
   input  logic          iCLEAR,
   input  logic          iPUSH,
   input  branch_entry_t iPUSH_DATA,
   input  logic          iPOP,
   output branch_entry_t oHEAD,
   output logic [AW:0]   oCOUNT,
   output logic          oFULL,
   output logic          oEMPTY
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   branch_entry_t mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign oFULL   = (count == FULL_CNT);
   assign oEMPTY  = (count == '0);
   assign oCOUNT  = count;
   assign oHEAD   = mem[rptr];
   assign pop_ok  = iPOP & ~oEMPTY;
   assign push_ok = iPUSH & (~oFULL | pop_ok);

   // Entry storage; contents are only meaningful while counted.
   always_ff @(posedge iCLOCK) begin
      if (push_ok && !iCLEAR) begin
         mem[wptr] <= iPUSH_DATA;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC || iCLEAR) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         count <= count + {{AW{1'b0}}, push_ok}
                        - {{AW{1'b0}}, pop_ok};
      end
   end

endmodule

// File: rtl/fetch_branch_resolve.sv
// Tracks predicted branches from decode to execute resolution,
// updates the branch cache and raises redirects on misprediction.
module fetch_branch_resolve
   import fetch_branch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        iCLOCK,
   input  logic        iRESET_SYNC,
   input  logic        iFLUSH,
   input  logic        iPUSH_STB,
   input  logic [31:0] iPUSH_INST_ADDR,
   input  logic        iPUSH_HIT,
   input  logic        iPUSH_PREDICT,
   input  logic [31:0] iPUSH_TARGET,
   output logic        oPUSH_FULL,
   input  logic        iRESOLVE_STB,
   input  logic        iRESOLVE_JUMP,
   input  logic [31:0] iRESOLVE_ADDR,
   output logic        oJUMP_STB,
   output logic        oJUMP_PREDICT,
   output logic        oJUMP_HIT,
   output logic        oJUMP_JUMP,
   output logic [31:0] oJUMP_ADDR,
   output logic [31:0] oJUMP_INST_ADDR,
   output logic        oMISS_VALID,
   output logic [31:0] oMISS_ADDR,
   output logic [31:0] oSTAT_BRANCH,
   output logic [31:0] oSTAT_MISS,
   output logic        oERROR
);

   state_t        state;
   branch_entry_t head;
   branch_entry_t push_data;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          live;
   logic          res_ok;
   logic          res_err;
   logic          mis;
   logic          push_ok;
   logic          push_err;

   assign push_data = '{inst_addr: iPUSH_INST_ADDR,
                        hit:       iPUSH_HIT,
                        predict:   iPUSH_PREDICT,
                        target:    iPUSH_TARGET};

   // Flush and the wrong-path wait state both mask decode and execute.
   assign live     = (state == RUN) & ~iFLUSH;
   assign res_ok   = live & iRESOLVE_STB & ~empty;
   assign res_err  = live & iRESOLVE_STB & empty;
   assign mis      = res_ok & is_mispredict(head, iRESOLVE_JUMP, iRESOLVE_ADDR);
   assign push_ok  = live & iPUSH_STB & ~mis & (~full | res_ok);
   assign push_err = live & iPUSH_STB & full & ~res_ok;
   assign oPUSH_FULL = full;

   fetch_branch_resolve_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .iCLEAR      (iFLUSH | mis),
      .iPUSH       (push_ok),
      .iPUSH_DATA  (push_data),
      .iPOP        (res_ok),
      .oHEAD       (head),
      .oCOUNT      (count),
      .oFULL       (full),
      .oEMPTY      (empty)
   );

   // Resolve FSM with registered cache-update, redirect, stats and error outputs.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state           <= RUN;
         oJUMP_STB       <= 1'b0;
         oJUMP_PREDICT   <= 1'b0;
         oJUMP_HIT       <= 1'b0;
         oJUMP_JUMP      <= 1'b0;
         oJUMP_ADDR      <= '0;
         oJUMP_INST_ADDR <= '0;
         oMISS_VALID     <= 1'b0;
         oMISS_ADDR      <= '0;
         oSTAT_BRANCH    <= '0;
         oSTAT_MISS      <= '0;
         oERROR          <= 1'b0;
      end else begin
         oJUMP_STB   <= res_ok;
         oMISS_VALID <= mis;
         if (iFLUSH) begin
            state <= RUN;
         end else if (mis) begin
            state <= MISS_WAIT;
         end
         if (res_ok) begin
            oJUMP_PREDICT   <= head.predict;
            oJUMP_HIT       <= head.hit;
            oJUMP_JUMP      <= iRESOLVE_JUMP;
            oJUMP_ADDR      <= iRESOLVE_ADDR;
            oJUMP_INST_ADDR <= head.inst_addr;
            oMISS_ADDR      <= iRESOLVE_JUMP ? iRESOLVE_ADDR
                                             : head.inst_addr + 32'd4;
            if (oSTAT_BRANCH != '1) oSTAT_BRANCH <= oSTAT_BRANCH + 32'd1;
         end
         if (mis && oSTAT_MISS != '1) begin
            oSTAT_MISS <= oSTAT_MISS + 32'd1;
         end
         if (res_err || push_err) begin
            oERROR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_branch_resolve.sv
// Directed bench for fetch_branch_resolve.
// A queue model predicts each resolve; results are scoreboarded one cycle later.
module tb_fetch_branch_resolve;

   logic        iCLOCK = 1'b0;
   logic        iRESET_SYNC;
   logic        iFLUSH;
   logic        iPUSH_STB;
   logic [31:0] iPUSH_INST_ADDR;
   logic        iPUSH_HIT;
   logic        iPUSH_PREDICT;
   logic [31:0] iPUSH_TARGET;
   logic        oPUSH_FULL;
   logic        iRESOLVE_STB;
   logic        iRESOLVE_JUMP;
   logic [31:0] iRESOLVE_ADDR;
   logic        oJUMP_STB;
   logic        oJUMP_PREDICT;
   logic        oJUMP_HIT;
   logic        oJUMP_JUMP;
   logic [31:0] oJUMP_ADDR;
   logic [31:0] oJUMP_INST_ADDR;
   logic        oMISS_VALID;
   logic [31:0] oMISS_ADDR;
   logic [31:0] oSTAT_BRANCH;
   logic [31:0] oSTAT_MISS;
   logic        oERROR;

   fetch_branch_resolve dut (
      .iCLOCK          (iCLOCK),
      .iRESET_SYNC     (iRESET_SYNC),
      .iFLUSH          (iFLUSH),
      .iPUSH_STB       (iPUSH_STB),
      .iPUSH_INST_ADDR (iPUSH_INST_ADDR),
      .iPUSH_HIT       (iPUSH_HIT),
      .iPUSH_PREDICT   (iPUSH_PREDICT),
      .iPUSH_TARGET    (iPUSH_TARGET),
      .oPUSH_FULL      (oPUSH_FULL),
      .iRESOLVE_STB    (iRESOLVE_STB),
      .iRESOLVE_JUMP   (iRESOLVE_JUMP),
      .iRESOLVE_ADDR   (iRESOLVE_ADDR),
      .oJUMP_STB       (oJUMP_STB),
      .oJUMP_PREDICT   (oJUMP_PREDICT),
      .oJUMP_HIT       (oJUMP_HIT),
      .oJUMP_JUMP      (oJUMP_JUMP),
      .oJUMP_ADDR      (oJUMP_ADDR),
      .oJUMP_INST_ADDR (oJUMP_INST_ADDR),
      .oMISS_VALID     (oMISS_VALID),
      .oMISS_ADDR      (oMISS_ADDR),
      .oSTAT_BRANCH    (oSTAT_BRANCH),
      .oSTAT_MISS      (oSTAT_MISS),
      .oERROR          (oERROR)
   );

   always #5 iCLOCK = ~iCLOCK;

   typedef struct {
      logic [31:0] inst;
      logic        hit;
      logic        pred;
      logic [31:0] tgt;
   } ent_t;

   typedef struct {
      logic [31:0] inst;
      logic        hit;
      logic        pred;
      logic        jump;
      logic [31:0] addr;
      logic        miss;
      logic [31:0] maddr;
   } exp_t;

   int          vectors = 0;
   int          miscompares = 0;
   ent_t        mq[$];
   exp_t        expq[$];
   logic        m_run = 1'b1;
   logic        m_err = 1'b0;
   logic [31:0] m_br = '0;
   logic [31:0] m_miss = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      exp_t e;
      chk("err", 32'(oERROR), 32'(m_err));
      chk("full", 32'(oPUSH_FULL), 32'(mq.size() == 8));
      chk("stat_br", oSTAT_BRANCH, m_br);
      chk("stat_miss", oSTAT_MISS, m_miss);
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("jump_stb", 32'(oJUMP_STB), 32'd1);
         chk("jump_inst", oJUMP_INST_ADDR, e.inst);
         chk("jump_addr", oJUMP_ADDR, e.addr);
         chk("jump_hit", 32'(oJUMP_HIT), 32'(e.hit));
         chk("jump_pred", 32'(oJUMP_PREDICT), 32'(e.pred));
         chk("jump_jump", 32'(oJUMP_JUMP), 32'(e.jump));
         chk("miss_valid", 32'(oMISS_VALID), 32'(e.miss));
         if (e.miss) chk("miss_addr", oMISS_ADDR, e.maddr);
      end else begin
         chk("jump_stb_idle", 32'(oJUMP_STB), 32'd0);
         chk("miss_idle", 32'(oMISS_VALID), 32'd0);
      end
   endtask

   task automatic drive(input logic p, input logic [31:0] pa,
                        input logic ph, input logic pp,
                        input logic [31:0] pt, input logic r,
                        input logic rj, input logic [31:0] ra,
                        input logic f);
      ent_t e;
      exp_t x;
      logic mis;
      logic tp;
      iPUSH_STB       = p;
      iPUSH_INST_ADDR = pa;
      iPUSH_HIT       = ph;
      iPUSH_PREDICT   = pp;
      iPUSH_TARGET    = pt;
      iRESOLVE_STB    = r;
      iRESOLVE_JUMP   = rj;
      iRESOLVE_ADDR   = ra;
      iFLUSH          = f;
      mis = 1'b0;
      if (f) begin
         mq.delete();
         m_run = 1'b1;
      end else if (m_run) begin
         if (r) begin
            if (mq.size() == 0) begin
               m_err = 1'b1;
            end else begin
               e  = mq.pop_front();
               tp = e.hit & e.pred;
               mis = (tp != rj) || (tp && rj && e.tgt != ra);
               x.inst  = e.inst;
               x.hit   = e.hit;
               x.pred  = e.pred;
               x.jump  = rj;
               x.addr  = ra;
               x.miss  = mis;
               x.maddr = rj ? ra : e.inst + 32'd4;
               expq.push_back(x);
               m_br++;
               if (mis) begin
                  m_miss++;
                  mq.delete();
                  m_run = 1'b0;
               end
            end
         end
         if (p && !mis) begin
            if (mq.size() < 8) begin
               e.inst = pa;
               e.hit  = ph;
               e.pred = pp;
               e.tgt  = pt;
               mq.push_back(e);
            end else begin
               m_err = 1'b1;
            end
         end
      end
      @(posedge iCLOCK);
      #1;
      iPUSH_STB    = 1'b0;
      iRESOLVE_STB = 1'b0;
      iFLUSH       = 1'b0;
      check_all();
   endtask

   task automatic push(input logic [31:0] a, input logic h,
                       input logic pr, input logic [31:0] t);
      drive(1'b1, a, h, pr, t, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic resolve(input logic j, input logic [31:0] a);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, j, a, 1'b0);
   endtask

   task automatic flush();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      iRESET_SYNC     = 1'b1;
      iFLUSH          = 1'b0;
      iPUSH_STB       = 1'b0;
      iPUSH_INST_ADDR = '0;
      iPUSH_HIT       = 1'b0;
      iPUSH_PREDICT   = 1'b0;
      iPUSH_TARGET    = '0;
      iRESOLVE_STB    = 1'b0;
      iRESOLVE_JUMP   = 1'b0;
      iRESOLVE_ADDR   = '0;
      repeat (2) @(posedge iCLOCK);
      #1;
      iRESET_SYNC = 1'b0;

      // reset state
      chk("rst_jump_addr", oJUMP_ADDR, 32'h0);
      chk("rst_jump_inst", oJUMP_INST_ADDR, 32'h0);
      chk("rst_miss_addr", oMISS_ADDR, 32'h0);
      chk("rst_flags", {26'h0, oJUMP_STB, oJUMP_PREDICT, oJUMP_HIT,
                        oJUMP_JUMP, oMISS_VALID, oERROR}, 32'h0);
      idle();

      // correct taken prediction
      push(32'h1000, 1'b1, 1'b1, 32'h2000);
      resolve(1'b1, 32'h2000);
      idle();

      // miss on a cold branch, wrong-path traffic ignored until flush
      push(32'h1000, 1'b0, 1'b0, 32'h0);
      resolve(1'b1, 32'h3000);
      push(32'h5000, 1'b1, 1'b1, 32'h6000);
      resolve(1'b0, 32'h0);
      idle();
      flush();
      push(32'h7000, 1'b0, 1'b0, 32'h0);
      resolve(1'b0, 32'h0);

      // not-taken fall-through wraps at the top of the address space
      push(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h2000);
      resolve(1'b0, 32'h0);
      flush();

      // fill, push-with-pop at full, overflow drop, then drain
      for (int i = 0; i < 8; i++) begin
         push(32'h100 + 32'(i * 4), 1'b1, 1'b0, 32'h0);
      end
      drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      push(32'h204, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         resolve(1'b0, 32'h0);
      end
      idle();

      // empty resolve, flush beating a same-cycle resolve
      resolve(1'b1, 32'h4000);
      push(32'h300, 1'b1, 1'b1, 32'h400);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 1'b1);
      resolve(1'b1, 32'h400);

      // push in a mispredicting cycle is discarded
      push(32'h800, 1'b1, 1'b1, 32'h900);
      drive(1'b1, 32'h804, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA00, 1'b0);
      flush();
      push(32'hC00, 1'b0, 1'b0, 32'h0);
      resolve(1'b0, 32'h0);

      // reset mid-operation discards everything
      push(32'hD00, 1'b1, 1'b1, 32'hE00);
      push(32'hD04, 1'b1, 1'b1, 32'hE04);
      iRESET_SYNC   = 1'b1;
      iRESOLVE_STB  = 1'b1;
      iRESOLVE_JUMP = 1'b0;
      @(posedge iCLOCK);
      #1;
      iRESET_SYNC  = 1'b0;
      iRESOLVE_STB = 1'b0;
      mq.delete();
      expq.delete();
      m_run  = 1'b1;
      m_err  = 1'b0;
      m_br   = '0;
      m_miss = '0;
      check_all();
      resolve(1'b1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
